// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end: reset/bubble defaults,
// instruction-memory depth and the fetch FSM state encoding.
package mips_pipe_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR  = 32'h0000_0000;
    localparam int          DEFAULT_IMEM_WORDS = 128;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    // Instruction fetches are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: bubble has priority over hold, hold over load.
// IFID valid is high only while the register carries a fetched instruction.
module ifid_register
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] next_instruction,
    input  logic [31:0] next_pc_plus4,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            instruction <= NOP_INSTR;
            pc_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (!hold) begin
            instruction <= next_instruction;
            pc_plus4    <= next_pc_plus4;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID control.
// Optional out-of-range fetch trapping is enabled by FETCH_BOUNDS_CHECK_EN.
module instruction_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Stall,
    input  logic         Flush,
    input  logic         Redirect,
    input  logic [31:0]  RedirectPC,
    output logic [31:0]  IM_Address,
    input  logic [31:0]  IM_Instruction,
    output logic [31:0]  IFID_Instruction,
    output logic [31:0]  IFID_PCPlus4,
    output logic         IFID_Valid,
    output logic         FetchFault,
    output fetch_state_t fetch_state
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_plus4;
    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         out_of_range;
    logic         in_fault;
    logic         fault_enter;
    logic         ifid_bubble;
    logic         ifid_hold;

    assign pc_plus4   = pc_q + 32'd4;
    assign IM_Address = pc_q;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign out_of_range = (pc_q >= IMEM_BYTES);
`else
    // Without bounds checking the memory index simply wraps on bits [8:2].
    logic unused_range;
    assign unused_range = (pc_q >= IMEM_BYTES);
    assign out_of_range = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (out_of_range && !Redirect) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (Redirect) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        in_fault    = (state_q == ST_FAULT);
        fault_enter = (state_q == ST_RUN) && out_of_range && !Redirect;
        ifid_bubble = Flush || Redirect || in_fault || fault_enter;
        ifid_hold   = Stall;
        fetch_state = state_q;
`ifdef FETCH_BOUNDS_CHECK_EN
        FetchFault  = in_fault;
`else
        FetchFault  = 1'b0;
`endif
    end

    // A faulting fetch parks the PC until a redirect rescues it.
    always_comb begin
        pc_d = pc_plus4;
        if (Redirect) begin
            pc_d = word_align(RedirectPC);
        end else if (Stall || in_fault || fault_enter) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifid_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_register (
        .clk              (Clk),
        .rst_n            (Rst_n),
        .bubble           (ifid_bubble),
        .hold             (ifid_hold),
        .next_instruction (IM_Instruction),
        .next_pc_plus4    (pc_plus4),
        .instruction      (IFID_Instruction),
        .pc_plus4         (IFID_PCPlus4),
        .valid            (IFID_Valid)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; the bounds scenario runs when
// FETCH_BOUNDS_CHECK_EN is defined, the wrap scenario otherwise.
module tb_instruction_fetch_stage;
    import mips_pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic         Clk;
    logic         Rst_n;
    logic         Stall;
    logic         Flush;
    logic         Redirect;
    logic [31:0]  RedirectPC;
    logic [31:0]  IM_Address;
    logic [31:0]  IM_Instruction;
    logic [31:0]  IFID_Instruction;
    logic [31:0]  IFID_PCPlus4;
    logic         IFID_Valid;
    logic         FetchFault;
    fetch_state_t fetch_state;

    logic [31:0] mem [128];
    int checks;
    int errors;

    instruction_fetch_stage dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .Stall            (Stall),
        .Flush            (Flush),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .IM_Address       (IM_Address),
        .IM_Instruction   (IM_Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .FetchFault       (FetchFault),
        .fetch_state      (fetch_state)
    );

    assign IM_Instruction = mem[IM_Address[8:2]];

    // Clock and reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one edge and settle before sampling/driving.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Stall = 1'b1; Flush = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        step();
        Rst_n = 1'b1; idle();
        checks++; if (IM_Address !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", IM_Address, 32'h0); end
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IFID_Valid); end
        checks++; if (IFID_Instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", IFID_Instruction, NOP); end
        checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got %h exp 0", IFID_PCPlus4); end
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", FetchFault); end
        checks++; if (fetch_state !== ST_RUN) begin errors++; $display("FAIL reset_state got %0d exp 0", fetch_state); end
        step();
        checks++; if (IFID_Instruction !== 32'hA000_0000) begin errors++; $display("FAIL first_instr got %h exp %h", IFID_Instruction, 32'hA000_0000); end
        checks++; if (IFID_PCPlus4 !== 32'h4) begin errors++; $display("FAIL first_pcp4 got %h exp 4", IFID_PCPlus4); end
        checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", IFID_Valid); end
        checks++; if (IM_Address !== 32'h4) begin errors++; $display("FAIL first_pc got %h exp 4", IM_Address); end
    endtask

    task automatic test_stall();
        step();
        checks++; if (IM_Address !== 32'h8) begin errors++; $display("FAIL pre_stall_pc got %h exp 8", IM_Address); end
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (IM_Address !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 8", i, IM_Address); end
            checks++; if (IFID_Instruction !== 32'hA000_0001) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, IFID_Instruction, 32'hA000_0001); end
            checks++; if (IFID_PCPlus4 !== 32'h8) begin errors++; $display("FAIL stall_pcp4[%0d] got %h exp 8", i, IFID_PCPlus4); end
        end
        Stall = 1'b0;
        step();
        checks++; if (IM_Address !== 32'hC) begin errors++; $display("FAIL unstall_pc got %h exp c", IM_Address); end
        checks++; if (IFID_Instruction !== 32'hA000_0002) begin errors++; $display("FAIL unstall_instr got %h exp %h", IFID_Instruction, 32'hA000_0002); end
        checks++; if (IFID_PCPlus4 !== 32'hC) begin errors++; $display("FAIL unstall_pcp4 got %h exp c", IFID_PCPlus4); end
    endtask

    task automatic test_flush();
        step();
        step();
        checks++; if (IM_Address !== 32'h14) begin errors++; $display("FAIL pre_flush_pc got %h exp 14", IM_Address); end
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", IFID_Valid); end
        checks++; if (IFID_Instruction !== NOP) begin errors++; $display("FAIL flush_instr got %h exp %h", IFID_Instruction, NOP); end
        checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL flush_pcp4 got %h exp 0", IFID_PCPlus4); end
        checks++; if (IM_Address !== 32'h18) begin errors++; $display("FAIL flush_pc got %h exp 18", IM_Address); end
        step();
        checks++; if (IFID_Instruction !== 32'hA000_0006) begin errors++; $display("FAIL post_flush_instr got %h exp %h", IFID_Instruction, 32'hA000_0006); end
        checks++; if (IFID_PCPlus4 !== 32'h1C) begin errors++; $display("FAIL post_flush_pcp4 got %h exp 1c", IFID_PCPlus4); end
    endtask

    task automatic test_redirect();
        Redirect = 1'b1; RedirectPC = 32'h0000_0042; Stall = 1'b1;
        step();
        idle();
        checks++; if (IM_Address !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp 40", IM_Address); end
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", IFID_Valid); end
        step();
        checks++; if (IFID_Instruction !== 32'hA000_0010) begin errors++; $display("FAIL redir_instr got %h exp %h", IFID_Instruction, 32'hA000_0010); end
        checks++; if (IFID_PCPlus4 !== 32'h44) begin errors++; $display("FAIL redir_pcp4 got %h exp 44", IFID_PCPlus4); end
        checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL redir_valid2 got %b exp 1", IFID_Valid); end
    endtask

    task automatic test_stall_flush();
        Stall = 1'b1; Flush = 1'b1;
        step();
        idle();
        checks++; if (IM_Address !== 32'h44) begin errors++; $display("FAIL sf_pc got %h exp 44", IM_Address); end
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL sf_valid got %b exp 0", IFID_Valid); end
        step();
        checks++; if (IFID_Instruction !== 32'hA000_0011) begin errors++; $display("FAIL sf_instr got %h exp %h", IFID_Instruction, 32'hA000_0011); end
        checks++; if (IFID_PCPlus4 !== 32'h48) begin errors++; $display("FAIL sf_pcp4 got %h exp 48", IFID_PCPlus4); end
    endtask

`ifdef FETCH_BOUNDS_CHECK_EN
    task automatic test_bounds();
        Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        step();
        idle();
        checks++; if (IM_Address !== 32'h200) begin errors++; $display("FAIL bnd_pc0 got %h exp 200", IM_Address); end
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL bnd_fault0 got %b exp 0", FetchFault); end
        for (int i = 0; i < 3; i++) begin
            Stall = (i == 1);
            step();
            checks++; if (FetchFault !== 1'b1) begin errors++; $display("FAIL bnd_fault[%0d] got %b exp 1", i, FetchFault); end
            checks++; if (IM_Address !== 32'h200) begin errors++; $display("FAIL bnd_pc[%0d] got %h exp 200", i, IM_Address); end
            checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL bnd_valid[%0d] got %b exp 0", i, IFID_Valid); end
            checks++; if (fetch_state !== ST_FAULT) begin errors++; $display("FAIL bnd_state[%0d] got %0d exp 1", i, fetch_state); end
        end
        Stall = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0004;
        step();
        idle();
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL bnd_clear got %b exp 0", FetchFault); end
        checks++; if (IM_Address !== 32'h4) begin errors++; $display("FAIL bnd_rpc got %h exp 4", IM_Address); end
        step();
        checks++; if (IFID_Instruction !== 32'hA000_0001) begin errors++; $display("FAIL bnd_instr got %h exp %h", IFID_Instruction, 32'hA000_0001); end
        checks++; if (IFID_PCPlus4 !== 32'h8) begin errors++; $display("FAIL bnd_pcp4 got %h exp 8", IFID_PCPlus4); end
        // Re-enter FAULT, then reset out of it.
        Redirect = 1'b1; RedirectPC = 32'h0000_0300;
        step();
        idle();
        step();
        checks++; if (FetchFault !== 1'b1) begin errors++; $display("FAIL bnd_refault got %b exp 1", FetchFault); end
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL bnd_rst_fault got %b exp 0", FetchFault); end
        checks++; if (IM_Address !== 32'h0) begin errors++; $display("FAIL bnd_rst_pc got %h exp 0", IM_Address); end
    endtask
`else
    task automatic test_wrap();
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        step();
        idle();
        checks++; if (IM_Address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffffc", IM_Address); end
        step();
        checks++; if (IM_Address !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", IM_Address); end
        checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got %h exp 0", IFID_PCPlus4); end
        checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", IFID_Valid); end
        checks++; if (IFID_Instruction !== 32'hA000_007F) begin errors++; $display("FAIL wrap_instr got %h exp %h", IFID_Instruction, 32'hA000_007F); end
        // Out-of-range address aliases onto bits [8:2] and never faults.
        Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        step();
        idle();
        step();
        checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL nofault got %b exp 0", FetchFault); end
        checks++; if (IFID_Instruction !== 32'hA000_0000) begin errors++; $display("FAIL alias_instr got %h exp %h", IFID_Instruction, 32'hA000_0000); end
        checks++; if (IFID_PCPlus4 !== 32'h204) begin errors++; $display("FAIL alias_pcp4 got %h exp 204", IFID_PCPlus4); end
        checks++; if (IM_Address !== 32'h204) begin errors++; $display("FAIL alias_pc got %h exp 204", IM_Address); end
    endtask
`endif

    task automatic test_reset_mid();
        Stall = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0000_0080; Flush = 1'b1;
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1; idle();
        checks++; if (IM_Address !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h exp 0", IM_Address); end
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", IFID_Valid); end
        step();
        checks++; if (IFID_Instruction !== 32'hA000_0000) begin errors++; $display("FAIL mid_rst_instr got %h exp %h", IFID_Instruction, 32'hA000_0000); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
        Rst_n = 1'b0;
        idle();
        #2;
        test_reset();
        test_stall();
        test_flush();
        test_redirect();
        test_stall_flush();
`ifdef FETCH_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 128, instruction-memory depth in words (index = address bits [8:2]).
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted for bubbles.
REQ-004 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port Stall, input, 1, hold PC and IF/ID register.
REQ-007 SHALL have port Flush, input, 1, load bubble into IF/ID.
REQ-008 SHALL have port Redirect, input, 1, branch/jump taken this cycle.
REQ-009 SHALL have port RedirectPC, input, 32, redirect target address.
REQ-010 SHALL have port IM_Address, output, 32, byte address to instruction memory, combinationally equal to the PC register.
REQ-011 SHALL have port IM_Instruction, input, 32, combinational read data from instruction memory.
REQ-012 SHALL have port IFID_Instruction, output, 32, registered instruction to decode.
REQ-013 SHALL have port IFID_PCPlus4, output, 32, registered PC+4 of that instruction.
REQ-014 SHALL have port IFID_Valid, output, 1, high when the IF/ID register holds a real instruction.
REQ-015 SHALL have port FetchFault, output, 1, out-of-range fetch indicator (constant 0 when feature compiled out).

Function
REQ-016 SHALL read memory combinationally: instruction for PC is captured into IF/ID at the next edge (1-cycle fetch latency).
REQ-017 SHALL compute next PC with priority: reset > Redirect > Stall > PC+4.
REQ-018 SHALL force RedirectPC[1:0] to 2'b00 when loading it into PC.
REQ-019 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 SHALL load IF/ID with priority: reset > Flush or Redirect (bubble) > Stall (hold) > capture {IM_Instruction, PC+4, Valid=1}.
REQ-021 SHALL define bubble as IFID_Instruction=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0.
REQ-022 SHALL, on Stall with Flush both high, hold PC and load bubble into IF/ID.
REQ-023 SHALL, on Stall with Redirect both high, load RedirectPC into PC and bubble into IF/ID.
REQ-024 SHALL implement states RUN and FAULT; FAULT reachable only when FETCH_BOUNDS_CHECK_EN is defined.

Reset
REQ-025 SHALL, when Rst_n=0 at an edge, set PC=RESET_PC, IF/ID to bubble, state=RUN, FetchFault=0, regardless of other inputs.
REQ-026 SHALL treat reset asserted mid-stall, mid-redirect or in FAULT identically to REQ-025.

Configuration
REQ-027 SHALL use macro FETCH_BOUNDS_CHECK_EN.
REQ-028 SHALL, with macro defined, in RUN, when PC >= IMEM_WORDS*4 and not Redirect, enter FAULT instead of capturing; in FAULT hold PC, output bubble, FetchFault=1.
REQ-029 SHALL, with macro defined, leave FAULT to RUN only on Redirect (PC loaded from RedirectPC, fault cleared) or reset; Stall does not affect FAULT.
REQ-030 SHALL, without macro, never fault: address bits above [8:2] are ignored and FetchFault is tied to 0.

Structure
REQ-031 SHALL place RESET_PC default, NOP_INSTR default, IMEM_WORDS default and the RUN/FAULT state encoding in shared package mips_pipe_pkg.
REQ-032 SHALL use one sub-module, ifid_register, holding the IF/ID fields with hold/bubble/load controls; PC logic and FSM stay in the top.

Verification
REQ-033 SHALL check reset: Rst_n=0 one cycle, release -> IM_Address=0, IFID_Valid=0; next edge -> IFID_Instruction=mem[0], IFID_PCPlus4=4, Valid=1.
REQ-034 SHALL check stall: Stall=1 for 2 cycles at PC=8 -> IM_Address stays 8, IF/ID unchanged; release -> PC=12.
REQ-035 SHALL check redirect: Redirect=1, RedirectPC=32'h0000_0042 while Stall=1 -> PC=32'h40, IFID_Valid=0 next cycle, then mem[16] captured.
REQ-036 SHALL check flush: Flush=1 at PC=20 -> IFID_Valid=0, IFID_Instruction=NOP_INSTR, PC advances to 24.
REQ-037 SHALL check wrap: redirect to 32'hFFFF_FFFC, no stall, macro undefined -> next PC=0, IFID_PCPlus4=0, Valid=1.
REQ-038 SHALL check bounds (macro defined): redirect to 32'h200 -> FAULT, FetchFault=1, PC held 32'h200 for 3 cycles; redirect to 4 -> RUN, FetchFault=0, mem[1] captured.
